rom_arbiter: RTL

- Shares the single 32Kx8 program ROM between two read requesters: the CPU fetch port (primary) and an auxiliary port (DMA/debug/boot-copy).
- Fixed priority to the CPU, with a starvation guard that forces an aux slot after a bounded wait.
- Pipelined: one read accepted per cycle. Tracks which requester owns each in-flight read and steers read-valid back after the ROM read latency.
- Sits between the requesters and the rom wrapper (rom_addr/rom_data).

---
 rtl/rom_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/rom_arbiter.sv
// Two-port read arbiter for the shared program ROM: CPU has fixed priority,
// aux is protected by a starvation guard; read-valid follows each grant after RD_LAT cycles.
module rom_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 8,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              aux_req,
    input  logic [ADDR_W-1:0] aux_addr,
    output logic              aux_gnt,
    output logic              aux_rvalid,
    output logic [DATA_W-1:0] aux_rdata,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              aux_starving
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
    localparam bit         GUARD_ON   = (STARVE_MAX != 0);

    logic [7:0]        starve_cnt;
    logic [ADDR_W-1:0] last_addr;
    logic [RD_LAT-1:0] cpu_pipe;
    logic [RD_LAT-1:0] aux_pipe;
    logic              at_limit;
    logic              aux_wins;
    logic              gnt_any;

    // Grants are combinational and held low while reset is asserted.
    always_comb begin
        at_limit = GUARD_ON && (starve_cnt == STARVE_LIM);
        aux_wins = aux_req && (!cpu_req || at_limit);
        cpu_gnt  = sys_rst_n && cpu_req && !aux_wins;
        aux_gnt  = sys_rst_n && aux_wins;
        gnt_any  = cpu_gnt || aux_gnt;
        rom_addr = last_addr;
        if (aux_gnt) begin
            rom_addr = aux_addr;
        end else if (cpu_gnt) begin
            rom_addr = cpu_addr;
        end
    end

    assign aux_starving = at_limit;

    // Counts consecutive denied aux cycles; with STARVE_MAX=0 the limit is 0 and it never moves.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            starve_cnt <= 8'd0;
        end else if (!aux_req || aux_gnt) begin
            starve_cnt <= 8'd0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            last_addr <= '0;
        end else if (gnt_any) begin
            last_addr <= rom_addr;
        end
    end

    // The {valid, owner} pipeline is kept one-hot as a CPU and an aux bit per stage,
    // so the last stage drives both rvalid outputs straight from flops.
    generate
        if (RD_LAT == 1) begin : g_lat1
            always_ff @(posedge clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    cpu_pipe <= '0;
                    aux_pipe <= '0;
                end else begin
                    cpu_pipe <= cpu_gnt;
                    aux_pipe <= aux_gnt;
                end
            end
        end else begin : g_latn
            always_ff @(posedge clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    cpu_pipe <= '0;
                    aux_pipe <= '0;
                end else begin
                    cpu_pipe <= {cpu_pipe[RD_LAT-2:0], cpu_gnt};
                    aux_pipe <= {aux_pipe[RD_LAT-2:0], aux_gnt};
                end
            end
        end
    endgenerate

    assign cpu_rvalid = cpu_pipe[RD_LAT-1];
    assign aux_rvalid = aux_pipe[RD_LAT-1];
    assign cpu_rdata  = rom_data;
    assign aux_rdata  = rom_data;

endmodule
